ssidft_frame_ctrl: RTL and testbench

- Frame sequencer for the sliding single-bin inverse DFT accumulator.
- On each output-sample tick it bursts all N spectrum bins out of a double-banked spectrum RAM and delivers them as one framed stream (sob/eob/bin value) to the iDFT stage.
- Owns the bank-swap handshake with the spectrum writer.
- Flags sample ticks that arrive while a frame is still in flight.

---
 rtl/ssidft_frame_ctrl_if.sv | 24 ++
 rtl/ssidft_frame_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ssidft_frame_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ssidft_frame_ctrl_if.sv
// Frame stream and spectrum-RAM read bus between the frame sequencer
// (master) and the RAM / iDFT stage (slave).
interface ssidft_frame_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 12
);
  logic                 mem_rd_en_o;
  logic [AW:0]          mem_rd_addr_o;
  logic signed [DW-1:0] mem_rd_data_i;
  logic                 sob_o;
  logic                 eob_o;
  logic                 bin_valid_o;
  logic signed [DW-1:0] freq_re_o;

  modport master (
    output mem_rd_en_o, mem_rd_addr_o, sob_o, eob_o, bin_valid_o, freq_re_o,
    input  mem_rd_data_i
  );

  modport slave (
    input  mem_rd_en_o, mem_rd_addr_o, sob_o, eob_o, bin_valid_o, freq_re_o,
    output mem_rd_data_i
  );
endinterface

// File: rtl/ssidft_frame_ctrl.sv
// Frame sequencer for the sliding single-bin inverse DFT accumulator.
// Each accepted sample tick bursts all N bins out of the active bank of a
// double-banked spectrum RAM and frames them (sob/eob/valid) for the iDFT.
// Optional macro SSIDFT_CTRL_BAND_LIMIT_EN adds band_lim_i: bins above the
// limit are still framed but not read from RAM and are forced to zero.
module ssidft_frame_ctrl #(
  parameter int DW     = 16,
  parameter int N      = 4096,
  parameter int AW     = $clog2(N),
  parameter int RD_LAT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 tick_i,
  input  logic                 bank_swap_i,
  input  logic                 overrun_clr_i,
`ifdef SSIDFT_CTRL_BAND_LIMIT_EN
  input  logic [AW-1:0]        band_lim_i,
`endif
  output logic                 bank_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  ssidft_frame_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [1:0]    LAT_INIT = 2'(RD_LAT - 1);

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic [AW-1:0]   cnt_d;
  logic [1:0]      lat_q;
  logic            bank_q;
  logic            pend_q;
  logic            ovr_q;
  logic            iss_q;     // a bin slot is issued this cycle
  logic            rd_en_q;   // that slot actually reads the RAM
  logic            rd_en_d;
  logic            first_q;
  logic            last_q;
  logic            accept_w;
  logic            drop_w;

  // read-valid pipeline: valid, first, last, zero-forced flags
  logic [RD_LAT-1:0] v_q;
  logic [RD_LAT-1:0] f_q;
  logic [RD_LAT-1:0] l_q;
  logic [RD_LAT-1:0] z_q;

`ifdef SSIDFT_CTRL_BAND_LIMIT_EN
  logic [AW-1:0]   band_q;
`endif

  assign accept_w = (state_q == IDLE) && tick_i && enable_i;
  assign drop_w   = (state_q != IDLE) && tick_i;

  // next bin index and whether that bin is inside the read band
  always_comb begin
    cnt_d   = cnt_q + AW'(1);
    rd_en_d = 1'b1;
`ifdef SSIDFT_CTRL_BAND_LIMIT_EN
    rd_en_d = (cnt_d <= band_q);
`endif
  end

  // frame FSM with registered issue-side outputs and bank selection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      bank_q  <= 1'b0;
      iss_q   <= 1'b0;
      rd_en_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef SSIDFT_CTRL_BAND_LIMIT_EN
      band_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (accept_w) begin
            state_q <= BURST;
            iss_q   <= 1'b1;
            rd_en_q <= 1'b1;          // bin 0 is always inside the band
            first_q <= 1'b1;
            last_q  <= 1'b0;
`ifdef SSIDFT_CTRL_BAND_LIMIT_EN
            band_q  <= band_lim_i;
`endif
            // a swap pulse in the accepting cycle already applies here
            if (pend_q || bank_swap_i) bank_q <= ~bank_q;
          end
        end
        BURST: begin
          first_q <= 1'b0;
          cnt_q   <= cnt_d;           // wraps to 0 after the last bin
          if (cnt_q == LAST_IDX) begin
            state_q <= DRAIN;
            iss_q   <= 1'b0;
            rd_en_q <= 1'b0;
            last_q  <= 1'b0;
            lat_q   <= LAT_INIT;
          end else begin
            rd_en_q <= rd_en_d;
            last_q  <= (cnt_d == LAST_IDX);
          end
        end
        DRAIN: begin
          // the final DRAIN cycle coincides with eob at the pipeline output
          if (lat_q == 2'd0) state_q <= IDLE;
          else               lat_q   <= lat_q - 2'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // swap request is remembered until the next frame is accepted
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)         pend_q <= 1'b0;
    else if (accept_w)    pend_q <= 1'b0;
    else if (bank_swap_i) pend_q <= 1'b1;
  end

  // sticky overrun; a dropped tick outranks the clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)           ovr_q <= 1'b0;
    else if (drop_w)        ovr_q <= 1'b1;
    else if (overrun_clr_i) ovr_q <= 1'b0;
  end

  // delay the issue flags by the RAM read latency
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v_q <= '0;
      f_q <= '0;
      l_q <= '0;
      z_q <= '0;
    end else begin
      v_q[0] <= iss_q;
      f_q[0] <= first_q;
      l_q[0] <= last_q;
      z_q[0] <= iss_q & ~rd_en_q;
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        f_q[i] <= f_q[i-1];
        l_q[i] <= l_q[i-1];
        z_q[i] <= z_q[i-1];
      end
    end
  end

  assign bus.mem_rd_en_o   = rd_en_q;
  assign bus.mem_rd_addr_o = {bank_q, cnt_q};
  assign bus.sob_o         = f_q[RD_LAT-1];
  assign bus.eob_o         = l_q[RD_LAT-1];
  assign bus.bin_valid_o   = v_q[RD_LAT-1];
  // RAM data passes straight through; held at zero outside valid bins and
  // for band-limited bins that were never read
  assign bus.freq_re_o     = (v_q[RD_LAT-1] && !z_q[RD_LAT-1]) ? bus.mem_rd_data_i : '0;

  assign bank_o    = bank_q;
  assign busy_o    = (state_q != IDLE);
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_ssidft_frame_ctrl.sv
// Bench for ssidft_frame_ctrl: two instances (RAM latency 1 and 3) share one
// random stimulus stream; a frame-timing model derived from tick acceptance
// times predicts every output cycle by cycle.
module tb_ssidft_frame_ctrl;
  localparam int DW = 16;
  localparam int N  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable, tick, bank_swap, overrun_clr;
`ifdef SSIDFT_CTRL_BAND_LIMIT_EN
  logic [AW-1:0] band_lim;
`endif
  logic bank1, busy1, ovr1, bank3, busy3, ovr3;

  ssidft_frame_ctrl_if #(.DW(DW), .AW(AW)) b1 ();
  ssidft_frame_ctrl_if #(.DW(DW), .AW(AW)) b3 ();

  ssidft_frame_ctrl #(.DW(DW), .N(N), .AW(AW), .RD_LAT(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .tick_i(tick),
    .bank_swap_i(bank_swap), .overrun_clr_i(overrun_clr),
`ifdef SSIDFT_CTRL_BAND_LIMIT_EN
    .band_lim_i(band_lim),
`endif
    .bank_o(bank1), .busy_o(busy1), .overrun_o(ovr1), .bus(b1));

  ssidft_frame_ctrl #(.DW(DW), .N(N), .AW(AW), .RD_LAT(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .tick_i(tick),
    .bank_swap_i(bank_swap), .overrun_clr_i(overrun_clr),
`ifdef SSIDFT_CTRL_BAND_LIMIT_EN
    .band_lim_i(band_lim),
`endif
    .bank_o(bank3), .busy_o(busy3), .overrun_o(ovr3), .bus(b3));

  // spectrum RAM contents, both banks
  logic [DW-1:0] ram [2*N];

  // RAM read pipelines; junk is returned when no read is issued
  logic [DW-1:0] p1 [1];
  logic [DW-1:0] p3 [3];
  always @(posedge clk) begin
    p1[0] <= b1.mem_rd_en_o ? ram[b1.mem_rd_addr_o] : DW'($urandom);
    p3[0] <= b3.mem_rd_en_o ? ram[b3.mem_rd_addr_o] : DW'($urandom);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b1.mem_rd_data_i = p1[0];
  assign b3.mem_rd_data_i = p3[2];

  // model state per instance: cycle of last accepted tick, bank, pending, overrun
  int lat   [2] = '{1, 3};
  int acc   [2];
  bit mbank [2];
  bit mpend [2];
  bit movr  [2];
  int mband [2];
  int cyc;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit busy_at(input int k, input int p);
    return (p >= acc[k] + 1) && (p <= acc[k] + N + lat[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      acc[k] = -1000; mbank[k] = 0; mpend[k] = 0; movr[k] = 0; mband[k] = N - 1;
    end
  endtask

  task automatic check_inst(input int k, input logic rd_en, input logic [AW:0] addr,
                            input logic sob, input logic eob, input logic vld,
                            input logic [DW-1:0] fr, input logic bnk, input logic bsy,
                            input logic ovr);
    int off, L, idx, vidx;
    string p;
    L    = lat[k];
    off  = cyc - acc[k];
    idx  = off - 1;
    vidx = off - L - 1;
    p    = $sformatf("L%0d_", L);
    chk({p, "rd_en"}, rd_en, (off >= 1 && off <= N && idx <= mband[k]));
    if (off >= 1 && off <= N) chk({p, "addr"}, addr, mbank[k] * N + idx);
    chk({p, "valid"}, vld, (off >= L + 1 && off <= N + L));
    chk({p, "sob"}, sob, (off == L + 1));
    chk({p, "eob"}, eob, (off == N + L));
    chk({p, "busy"}, bsy, (off >= 1 && off <= N + L));
    chk({p, "bank"}, bnk, mbank[k]);
    chk({p, "overrun"}, ovr, movr[k]);
    if (off >= L + 1 && off <= N + L)
      chk({p, "freq"}, fr, (vidx > mband[k]) ? 32'd0 : 32'(ram[mbank[k] * N + vidx]));
  endtask

  task automatic check_all();
    check_inst(0, b1.mem_rd_en_o, b1.mem_rd_addr_o, b1.sob_o, b1.eob_o, b1.bin_valid_o,
               b1.freq_re_o, bank1, busy1, ovr1);
    check_inst(1, b3.mem_rd_en_o, b3.mem_rd_addr_o, b3.sob_o, b3.eob_o, b3.bin_valid_o,
               b3.freq_re_o, bank3, busy3, ovr3);
  endtask

  // one clock: drive inputs for the current cycle, advance model, check next cycle
  task automatic step(input bit tk, input bit en, input bit sw, input bit cl);
    int bl;
    bit b;
    bl = N - 1;
`ifdef SSIDFT_CTRL_BAND_LIMIT_EN
    bl = int'($urandom_range(0, N - 1));
    band_lim = AW'(bl);
`endif
    tick = tk; enable = en; bank_swap = sw; overrun_clr = cl;
    for (int k = 0; k < 2; k++) begin
      b = busy_at(k, cyc);
      if (tk && b)  movr[k] = 1;
      else if (cl)  movr[k] = 0;
      if (!b && tk && en) begin
        acc[k] = cyc;
        if (mpend[k] || sw) mbank[k] = ~mbank[k];
        mpend[k] = 0;
        mband[k] = bl;
      end else if (sw) begin
        mpend[k] = 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    check_all();
  endtask

  // asynchronous reset in the middle of a cycle
  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rd_en", {b3.mem_rd_en_o, b1.mem_rd_en_o}, 0);
    chk("rst_addr", {b3.mem_rd_addr_o, b1.mem_rd_addr_o}, 0);
    chk("rst_frame", {b3.sob_o, b3.eob_o, b3.bin_valid_o, b1.sob_o, b1.eob_o, b1.bin_valid_o}, 0);
    chk("rst_freq", {b3.freq_re_o, b1.freq_re_o}, 0);
    chk("rst_status", {bank3, busy3, ovr3, bank1, busy1, ovr1}, 0);
    tick = 0; enable = 0; bank_swap = 0; overrun_clr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 2 * N; i++) ram[i] = DW'($urandom);
    rst_n = 1'b0; tick = 0; enable = 0; bank_swap = 0; overrun_clr = 0;
`ifdef SSIDFT_CTRL_BAND_LIMIT_EN
    band_lim = '0;
`endif
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    mid_reset();

    // directed: dropped tick, overrun clear, spacing 10, swaps mid-frame,
    // tick with enable low, same-cycle swap and accept
    for (int i = 0; i < 60; i++)
      step(i inside {0, 3, 10, 20, 30, 44, 52}, !(i inside {30}),
           i inside {5, 6, 44}, i inside {14});

    // reset during the 4th burst cycle, then a clean frame
    step(1, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    mid_reset();
    step(1, 1, 0, 0);
    repeat (14) step(0, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) mid_reset();
      else step($urandom_range(0, 5) == 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
